// File: rtl/dev_input_feeder_pkg.sv
// Shared definitions for the device-input feeder: code width, handshake FSM
// state encoding and the odd-parity helper used when DEV_INPUT_PARITY_EN is set.
package dev_input_feeder_pkg;

  localparam int DEV_CODE_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_VALID = 2'd2,
    ST_WAIT  = 2'd3
  } feeder_state_e;

  // Odd parity over code bits plus parity bit: a good word XORs to 1.
  function automatic logic odd_parity_ok(input logic [5:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/dev_input_feeder_sync_fifo.sv
// Single-clock show-ahead FIFO: head always presents the oldest entry, pushes
// are ignored when full and pops are ignored when empty.
module sync_fifo #(
  parameter int WIDTH      = 5,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; the count/pointers guarantee stale entries are
  // never observed, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dev_input_feeder.sv
// Host-to-core code feeder: FIFO of 5-bit tape codes presented over a
// four-phase rdy/val handshake. Optional parity filter: DEV_INPUT_PARITY_EN.
module dev_input_feeder
  import dev_input_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  host_wr_en,
  input  logic [7:0]            host_wr_data,
  output logic                  host_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  parity_err,
  input  logic                  clr_flags,
  input  logic                  dev_input_rdy,
  output logic                  dev_input_val,
  output logic [DEV_CODE_W-1:0] dev_input_data
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  feeder_state_e         state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEV_CODE_W-1:0] data_d;
  logic                  val_d;
  logic                  pop;
  logic                  parity_ok;
  logic                  push_req;
  logic                  fifo_empty;
  logic [DEV_CODE_W-1:0] fifo_head;
  logic                  unused_wr_bits;

`ifdef DEV_INPUT_PARITY_EN
  assign parity_ok      = odd_parity_ok(host_wr_data[5:0]);
  assign unused_wr_bits = ^host_wr_data[7:6];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       parity_err <= 1'b0;
    else if (host_wr_en && !parity_ok) parity_err <= 1'b1;
    else if (clr_flags)                parity_err <= 1'b0;
  end
`else
  assign parity_ok      = 1'b1;
  assign parity_err     = 1'b0;
  assign unused_wr_bits = ^host_wr_data[7:5];
`endif

  // Parity-dropped words never reach the FIFO, so they cannot count as overflow.
  assign push_req = host_wr_en && parity_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     overflow <= 1'b0;
    else if (push_req && host_full)  overflow <= 1'b1;
    else if (clr_flags)              overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH      (DEV_CODE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push_req),
    .pop     (pop),
    .wr_data (host_wr_data[DEV_CODE_W-1:0]),
    .head    (fifo_head),
    .full    (host_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      dev_input_data <= '0;
      dev_input_val  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dev_input_data <= data_d;
      dev_input_val  <= val_d;
    end
  end

  // NOTE: every output of this block gets a default before the case so that no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = dev_input_data;
    val_d   = dev_input_val;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        val_d = 1'b0;
        if (dev_input_rdy && !fifo_empty) begin
          data_d  = fifo_head;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (!dev_input_rdy) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SETUP_LAST) begin
          val_d   = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (!dev_input_rdy) begin
          pop     = 1'b1;
          val_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // rdy was seen low on the way in; one cycle here closes the four-phase cycle.
        val_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dev_input_feeder.sv
// Self-checking bench for dev_input_feeder: randomized codes checked against a
// queue model of the FIFO plus latency/flag rules of the handshake.
module tb_dev_input_feeder;

  localparam int DEPTH_LOG2   = 4;
  localparam int SETUP_CYCLES = 2;
  localparam int DEPTH        = 2 ** DEPTH_LOG2;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  host_wr_en;
  logic [7:0]            host_wr_data;
  logic                  host_full;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  overflow;
  logic                  parity_err;
  logic                  clr_flags;
  logic                  dev_input_rdy;
  logic                  dev_input_val;
  logic [4:0]            dev_input_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [4:0] model_q [$];
  bit         exp_ovf;
  bit         exp_perr;

  dev_input_feeder #(
    .DEPTH_LOG2   (DEPTH_LOG2),
    .SETUP_CYCLES (SETUP_CYCLES)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .host_wr_en     (host_wr_en),
    .host_wr_data   (host_wr_data),
    .host_full      (host_full),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .parity_err     (parity_err),
    .clr_flags      (clr_flags),
    .dev_input_rdy  (dev_input_rdy),
    .dev_input_val  (dev_input_val),
    .dev_input_data (dev_input_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit code_accepted(input logic [7:0] d);
`ifdef DEV_INPUT_PARITY_EN
    return ^d[5:0];
`else
    return 1'b1;
`endif
  endfunction

  // One push cycle; the model applies drop/overflow/store rules from the spec.
  task automatic push_code(input logic [7:0] d);
    host_wr_en   = 1'b1;
    host_wr_data = d;
    if (!code_accepted(d))            exp_perr = 1'b1;
    else if (model_q.size() == DEPTH) exp_ovf  = 1'b1;
    else                              model_q.push_back(d[4:0]);
    tick();
    host_wr_en = 1'b0;
  endtask

  // Full four-phase transfer; returns observed rise latency (-1 on timeout).
  task automatic handshake(output int lat, output logic [4:0] data, output bit fell);
    lat = 0;
    dev_input_rdy = 1'b1;
    while (!dev_input_val && lat < 50) begin
      tick();
      lat++;
    end
    if (!dev_input_val) lat = -1;
    data = dev_input_data;
    dev_input_rdy = 1'b0;
    tick();
    fell = !dev_input_val;
    if (lat > 0 && model_q.size() > 0) void'(model_q.pop_front());
    tick();
  endtask

  task automatic drain(input string tag);
    int         lat;
    logic [4:0] data;
    logic [4:0] exp;
    bit         fell;
    while (model_q.size() > 0) begin
      exp = model_q[0];
      handshake(lat, data, fell);
      total_cnt++;
      if (lat !== 1 + SETUP_CYCLES)
        $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, 1 + SETUP_CYCLES);
      else pass_cnt++;
      total_cnt++;
      if (data !== exp) $display("FAIL %s_data got=%h exp=%h", tag, data, exp);
      else pass_cnt++;
      total_cnt++;
      if (!fell) $display("FAIL %s_val_fall got=1 exp=0", tag);
      else pass_cnt++;
      total_cnt++;
      if (fifo_count !== (DEPTH_LOG2 + 1)'(model_q.size()))
        $display("FAIL %s_count got=%0d exp=%0d", tag, fifo_count, model_q.size());
      else pass_cnt++;
      if (lat < 0) return;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; host_wr_en = 1'b0; host_wr_data = '0;
    clr_flags = 1'b0; dev_input_rdy = 1'b0;
    model_q.delete(); exp_ovf = 1'b0; exp_perr = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    total_cnt++;
    if ({dev_input_val, dev_input_data, fifo_count, host_full, overflow, parity_err} !== '0)
      $display("FAIL reset_state got val=%b data=%h cnt=%0d full=%b ovf=%b perr=%b exp all 0",
               dev_input_val, dev_input_data, fifo_count, host_full, overflow, parity_err);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    push_code(8'h13);
    push_code(8'h04);
    total_cnt++;
    if (fifo_count !== 5'd2) $display("FAIL basic_count got=%0d exp=2", fifo_count);
    else pass_cnt++;
    drain("basic");
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) push_code(8'($urandom));
      total_cnt++;
      if (fifo_count !== (DEPTH_LOG2 + 1)'(model_q.size()))
        $display("FAIL rand_fill_count got=%0d exp=%0d", fifo_count, model_q.size());
      else pass_cnt++;
      drain("rand");
    end
    total_cnt++;
    if (parity_err !== exp_perr) $display("FAIL rand_parity_err got=%b exp=%b", parity_err, exp_perr);
    else pass_cnt++;
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    exp_perr = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic test_setup_abort();
    logic [4:0] exp;
    bit         rose = 1'b0;
    push_code({3'b001, 5'($urandom)});
    push_code({3'b001, 5'($urandom)});
    exp = model_q[0];
    dev_input_rdy = 1'b1;
    tick();
    dev_input_rdy = 1'b0;
    repeat (4) begin
      tick();
      if (dev_input_val) rose = 1'b1;
    end
    total_cnt++;
    if (rose) $display("FAIL abort_val got=1 exp=0");
    else pass_cnt++;
    total_cnt++;
    if (fifo_count !== (DEPTH_LOG2 + 1)'(model_q.size()))
      $display("FAIL abort_count got=%0d exp=%0d", fifo_count, model_q.size());
    else pass_cnt++;
    total_cnt++;
    if (model_q[0] !== exp) $display("FAIL abort_model got=%h exp=%h", model_q[0], exp);
    else pass_cnt++;
    drain("abort");
  endtask

  task automatic test_empty_stall();
    int lat = 0;
    bit rose = 1'b0;
    dev_input_rdy = 1'b1;
    repeat (5) begin
      tick();
      if (dev_input_val) rose = 1'b1;
    end
    total_cnt++;
    if (rose) $display("FAIL stall_val got=1 exp=0");
    else pass_cnt++;
    host_wr_en = 1'b1; host_wr_data = 8'h3F;
    while (!dev_input_val && lat < 50) begin
      tick();
      host_wr_en = 1'b0;
      lat++;
    end
    total_cnt++;
    if (lat !== 2 + SETUP_CYCLES) $display("FAIL stall_latency got=%0d exp=%0d", lat, 2 + SETUP_CYCLES);
    else pass_cnt++;
    total_cnt++;
    if (dev_input_data !== 5'h1F) $display("FAIL stall_data got=%h exp=1f", dev_input_data);
    else pass_cnt++;
    dev_input_rdy = 1'b0;
    tick(); tick();
    total_cnt++;
    if (fifo_count !== 5'd0) $display("FAIL stall_count got=%0d exp=0", fifo_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_valid();
    int lat = 0;
    push_code(8'h2A);
    push_code(8'h35);
    dev_input_rdy = 1'b1;
    while (!dev_input_val && lat < 50) begin
      tick();
      lat++;
    end
    total_cnt++;
    if (!dev_input_val) $display("FAIL rstmid_reach_valid got=0 exp=1");
    else pass_cnt++;
    resetn = 1'b0;
    #1;
    total_cnt++;
    if ({dev_input_val, dev_input_data, fifo_count} !== '0)
      $display("FAIL rstmid_async got val=%b data=%h cnt=%0d exp all 0",
               dev_input_val, dev_input_data, fifo_count);
    else pass_cnt++;
    dev_input_rdy = 1'b0;
    model_q.delete(); exp_ovf = 1'b0; exp_perr = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) push_code({3'b001, 5'($urandom)});
    total_cnt++;
    if (host_full !== 1'b1 || fifo_count !== (DEPTH_LOG2 + 1)'(DEPTH))
      $display("FAIL ovf_full got full=%b cnt=%0d exp full=1 cnt=%0d", host_full, fifo_count, DEPTH);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== exp_ovf || !exp_ovf) $display("FAIL ovf_flag got=%b exp=1", overflow);
    else pass_cnt++;
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; exp_ovf = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0 || fifo_count !== (DEPTH_LOG2 + 1)'(DEPTH))
      $display("FAIL ovf_clear got ovf=%b cnt=%0d exp ovf=0 cnt=%0d", overflow, fifo_count, DEPTH);
    else pass_cnt++;
    clr_flags = 1'b1;
    push_code(8'h21);
    clr_flags = 1'b0;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_event_beats_clear got=%b exp=1", overflow);
    else pass_cnt++;
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; exp_ovf = 1'b0;
    drain("ovf");
  endtask

  task automatic test_parity();
    push_code(8'h01);
    push_code(8'h21);
    total_cnt++;
    if (fifo_count !== (DEPTH_LOG2 + 1)'(model_q.size()))
      $display("FAIL parity_count got=%0d exp=%0d", fifo_count, model_q.size());
    else pass_cnt++;
    total_cnt++;
    if (parity_err !== exp_perr) $display("FAIL parity_flag got=%b exp=%b", parity_err, exp_perr);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL parity_no_ovf got=%b exp=0", overflow);
    else pass_cnt++;
    drain("parity");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_rounds();
    test_setup_abort();
    test_empty_stall();
    test_reset_mid_valid();
    test_overflow();
    test_parity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
